btn_debounce_ctrl: RTL and testbench
====================================

BTN_DEBOUNCE_CTRL -- requirements
Module: btn_debounce_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NBTN, 4, number of button channels (2..8).
- N, 2, prescaler width; sample strobe every 2^N clocks.
- CONFIRM, 3, consecutive equal samples needed to change level (2..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- in, in, NBTN, raw bouncing button inputs, asynchronous.
- out, out, NBTN, debounced levels.
- tick, out, NBTN, one-clock pulse per confirmed press (0->1).
- evt_valid, out, 1, press event available.
- evt_id, out, $clog2(NBTN), channel index of presented event.
- evt_ready, in, 1, consumer accepts event.
- ovf, out, 1, sticky: press lost because channel already pending.

Function
REQ-003 Each in[i] SHALL pass a 2-flop synchronizer; the FSM sees sync[i] 2 clocks after in[i] changes.
REQ-004 One shared N-bit free-running prescaler SHALL assert strobe in cycles where count == 2^N-1; the first strobe occurs 2^N clocks after reset release.
REQ-005 Each channel SHALL run FSM {ZERO, WAIT1, ONE, WAIT0} with a 4-bit confirm counter cnt; state changes only on strobe cycles.
REQ-006 ZERO: strobe and sync=1 -> WAIT1, cnt=1; else stay.
REQ-007 WAIT1: strobe and sync=0 -> ZERO; strobe and sync=1 -> cnt+1, and if cnt+1 == CONFIRM -> ONE.
REQ-008 ONE/WAIT0 SHALL mirror ZERO/WAIT1 with sync inverted; WAIT0 confirmed -> ZERO.
REQ-009 out[i] SHALL be 1 exactly in states ONE and WAIT0 (registered, Moore).
REQ-010 tick[i] SHALL be high for exactly the one clock after the WAIT1->ONE transition; release generates no tick and no event.
REQ-011 tick[i] SHALL set pending[i]; if pending[i] is already set and not cleared that cycle, ovf SHALL set and stay 1 until reset.
REQ-012 evt_valid SHALL be 1 whenever a grant is locked; with no lock and any pending bit, the arbiter SHALL lock the first pending index at or after rr_ptr (round-robin, wrap NBTN-1 -> 0), evt_valid rising the next clock.
REQ-013 While evt_valid=1 and evt_ready=0, evt_id SHALL hold stable regardless of new pending bits.
REQ-014 On evt_valid & evt_ready: clear pending[evt_id], rr_ptr = (evt_id+1) mod NBTN, release lock; a new lock may appear the following clock (max one event per 2 clocks).
REQ-015 Simultaneous tick[k] and acceptance of k in the same cycle: set wins, pending[k] stays 1, ovf not set.
REQ-016 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-017 Reset SHALL asynchronously clear synchronizers, prescaler, cnt, pending, rr_ptr, lock and ovf; all FSMs go to ZERO; out, tick, evt_valid, evt_id, ovf all 0.
REQ-018 Reset asserted mid-WAIT1/WAIT0 or with a locked event SHALL drop that state/event without emitting tick or handshake.

Structure
REQ-019 Package btn_pkg SHALL hold the db_state_t enum (ZERO, WAIT1, ONE, WAIT0) and default parameter constants.
REQ-020 Per-channel synchronizer+FSM+cnt SHALL be sub-module db_channel, instantiated NBTN times with the shared strobe; prescaler, pending, arbiter stay in the top.

Verification (NBTN=4, N=2, CONFIRM=3, 10 ns clock)
REQ-021 Reset held 2 cycles, in=0 -> all outputs 0; first strobe 4 clocks after release.
REQ-022 in[0] toggled every 20 ns for 10 toggles -> out[0]=0, tick[0] never asserted, evt_valid=0.
REQ-023 in[0]=1 held 200 ns, evt_ready=0 -> out[0]=1 within 15 clocks, single tick[0] pulse, evt_valid=1, evt_id=0 held until ready.
REQ-024 in[1] and in[3] rise same cycle, evt_ready=0 until both pending -> evt_id=1; one-cycle ready -> evt_id=3 presented; ready again -> evt_valid=0.
REQ-025 With evt_ready=0, channel 2 pressed, released, pressed -> ovf=1, one pending event; ovf stays 1 until reset.
REQ-026 Reset asserted while channel 0 in WAIT1 (2 strobes high) -> out/tick/evt_valid stay 0; after release, 3 fresh strobes needed to confirm.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button debounce controller.
//   db_state_t  : per-channel debounce FSM state
//   *_DEF       : default parameter values used by db_channel and btn_debounce_ctrl
package btn_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int unsigned NBTN_DEF    = 4;
    localparam int unsigned N_DEF       = 2;
    localparam int unsigned CONFIRM_DEF = 3;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-flop synchronizer, debounce FSM and confirm counter.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   raw    : raw bouncing input (asynchronous)
//   strobe : shared sample strobe, FSM only moves in strobe cycles
//   out    : debounced level (1 in ONE/WAIT0)
//   tick   : one-clock pulse in the cycle after a confirmed 0->1 change
module db_channel
    import btn_pkg::*;
#(
    parameter int unsigned CONFIRM = CONFIRM_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic strobe,
    output logic out,
    output logic tick
);

    localparam logic [CNT_W-1:0] CONF = CNT_W'(CONFIRM);

    logic             sync1_q, sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tick_q, tick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (strobe) begin
            unique case (state_q)
                ZERO: begin
                    if (sync2_q) begin
                        state_d = WAIT1;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT1: begin
                    if (!sync2_q) begin
                        state_d = ZERO;
                        cnt_d   = '0;
                    end else if (cnt_inc == CONF) begin
                        state_d = ONE;
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ONE: begin
                    if (!sync2_q) begin
                        state_d = WAIT0;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT0: begin
                    if (sync2_q) begin
                        state_d = ONE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CONF) begin
                        // release: no tick
                        state_d = ZERO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign out  = (state_q == ONE) || (state_q == WAIT0);
    assign tick = tick_q;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Multi-channel button debouncer with press-event round-robin arbiter.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   in        : raw button inputs
//   out       : debounced levels
//   tick      : one-clock pulse per confirmed press
//   evt_valid : a press event is presented
//   evt_id    : channel of the presented event (stable while not accepted)
//   evt_ready : consumer accepts the presented event
//   ovf       : sticky, a press was lost because its channel was still pending
module btn_debounce_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned NBTN    = NBTN_DEF,
    parameter int unsigned N       = N_DEF,
    parameter int unsigned CONFIRM = CONFIRM_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NBTN-1:0]         in,
    output logic [NBTN-1:0]         out,
    output logic [NBTN-1:0]         tick,
    output logic                    evt_valid,
    output logic [$clog2(NBTN)-1:0] evt_id,
    input  logic                    evt_ready,
    output logic                    ovf
);

    localparam int unsigned IDW = $clog2(NBTN);

    logic [N-1:0]    presc_q;
    logic            strobe;
    logic [NBTN-1:0] pend_q, pend_d, clr;
    logic            lock_q, lock_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic            ovf_q, ovf_d;
    logic            accept;
    logic            found;
    logic [IDW-1:0]  pick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + N'(1);
        end
    end

    assign strobe = &presc_q;

    for (genvar g = 0; g < NBTN; g++) begin : g_chan
        db_channel #(
            .CONFIRM(CONFIRM)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (in[g]),
            .strobe(strobe),
            .out   (out[g]),
            .tick  (tick[g])
        );
    end

    always_comb begin
        accept = lock_q & evt_ready;
        clr    = '0;
        if (accept) begin
            clr[grant_q] = 1'b1;
        end
        // a new tick wins over the clear of the same channel
        pend_d = (pend_q & ~clr) | tick;
        ovf_d  = ovf_q | (|(tick & pend_q & ~clr));

        // first pending index at or after rr_q, wrapping
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NBTN; k++) begin
            int unsigned j;
            j = (32'(rr_q) + k) % NBTN;
            if (!found && pend_q[IDW'(j)]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end

        lock_d  = lock_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (accept) begin
            lock_d = 1'b0;
            rr_d   = (grant_q == IDW'(NBTN - 1)) ? '0 : grant_q + IDW'(1);
        end else if (!lock_q && found) begin
            lock_d  = 1'b1;
            grant_d = pick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= '0;
            lock_q  <= 1'b0;
            grant_q <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            lock_q  <= lock_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = lock_q;
    assign evt_id    = grant_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Bench for btn_debounce_ctrl (NBTN=4, N=2, CONFIRM=3). A reference model advances once
// per clock edge; expected event ids go into a queue that a separate monitor drains on
// every handshake, while outputs are compared on the falling edge.
module tb_btn_debounce_ctrl;

    localparam int NBTN    = 4;
    localparam int CONFIRM = 3;
    localparam int PER     = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_r = '0;
    logic       evt_ready = 1'b0;
    logic [3:0] out, tick;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_debounce_ctrl #(
        .NBTN   (4),
        .N      (2),
        .CONFIRM(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_r),
        .out      (out),
        .tick     (tick),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .ovf      (ovf)
    );

    // reference model state
    int         n = 0;
    logic [3:0] h1 = '0, h2 = '0, lvl = '0, mtick = '0, mpend = '0;
    int         run[NBTN];
    bit         mlock = 0;
    int         mgrant = 0, mptr = 0;
    bit         movf = 0;
    int         exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] old;
        bit acc, strobe, fnd;
        if (reset) begin
            n = 0; h1 = '0; h2 = '0; lvl = '0; mtick = '0; mpend = '0;
            for (int i = 0; i < NBTN; i++) run[i] = 0;
            mlock = 0; mgrant = 0; mptr = 0; movf = 0;
            exp_q.delete();
            return;
        end
        // event bookkeeping driven by the tick visible during the closing cycle
        acc = mlock && evt_ready;
        old = mpend;
        if (acc) mpend[mgrant] = 1'b0;
        for (int i = 0; i < NBTN; i++) begin
            if (mtick[i]) begin
                if (old[i] && !(acc && mgrant == i)) movf = 1;
                mpend[i] = 1'b1;
            end
        end
        if (acc) begin
            mlock = 0;
            mptr  = (mgrant + 1) % NBTN;
        end else if (!mlock) begin
            fnd = 0;
            for (int k = 0; k < NBTN; k++) begin
                int j;
                j = (mptr + k) % NBTN;
                if (!fnd && old[j]) begin
                    fnd = 1; mlock = 1; mgrant = j;
                    exp_q.push_back(j);
                end
            end
        end
        // debounce: level flips after CONFIRM consecutive strobe samples differing from it
        n++;
        strobe = (n % PER) == 0;
        mtick = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (strobe) begin
                if (h2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == CONFIRM) begin
                        lvl[i] = ~lvl[i];
                        run[i] = 0;
                        if (lvl[i]) mtick[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
        h2 = h1;
        h1 = in_r;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        chk("out", int'(out), int'(lvl));
        chk("tick", int'(tick), int'(mtick));
        chk("evt_valid", int'(evt_valid), int'(mlock));
        chk("ovf", int'(ovf), int'(movf));
        if (mlock) chk("evt_id", int'(evt_id), mgrant);
        if (reset) chk("evt_id_reset", int'(evt_id), 0);
        if (evt_valid && evt_ready && !reset) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL handshake_unexpected: got id %0d expected no event at %0t",
                         evt_id, $time);
            end else begin
                chk("accepted_id", int'(evt_id), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align2();
        while (n % PER != 2) cyc(1);
    endtask

    initial begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("idle_out", int'(out), 0);

        // bounce in phase with the sampler so every sample reads 0
        align2();
        for (int t = 0; t < 10; t++) begin
            in_r[0] = ~in_r[0];
            cyc(2);
        end
        cyc(16);
        chk("bounce_out0", int'(out[0]), 0);
        chk("bounce_valid", int'(evt_valid), 0);

        // stable press, consumer not ready
        in_r[0] = 1'b1;
        cyc(24);
        chk("press_out0", int'(out[0]), 1);
        chk("press_valid", int'(evt_valid), 1);
        chk("press_id", int'(evt_id), 0);
        in_r[0] = 1'b0;
        cyc(20);
        chk("release_out0", int'(out[0]), 0);
        chk("held_id", int'(evt_id), 0);
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        cyc(2);
        chk("after_accept_valid", int'(evt_valid), 0);

        // simultaneous presses on 1 and 3
        in_r[1] = 1'b1; in_r[3] = 1'b1;
        cyc(24);
        chk("rr_first_id", int'(evt_id), 1);
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        cyc(2);
        chk("rr_second_valid", int'(evt_valid), 1);
        chk("rr_second_id", int'(evt_id), 3);
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        cyc(2);
        chk("rr_drained_valid", int'(evt_valid), 0);
        in_r = '0;
        cyc(20);

        // press, release, press on channel 2 without acceptance
        in_r[2] = 1'b1; cyc(20);
        in_r[2] = 1'b0; cyc(20);
        in_r[2] = 1'b1; cyc(20);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_id", int'(evt_id), 2);
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        in_r[2] = 1'b0;
        cyc(20);
        chk("ovf_sticky", int'(ovf), 1);
        chk("ovf_single_event", int'(evt_valid), 0);

        // reset during WAIT1 after two high strobes
        reset = 1'b1; cyc(2); reset = 1'b0;
        cyc(1);
        chk("reset_ovf", int'(ovf), 0);
        align2();
        in_r[0] = 1'b1;
        cyc(11);
        reset = 1'b1; cyc(2); reset = 1'b0;
        cyc(10);
        chk("fresh_not_yet", int'(out[0]), 0);
        cyc(10);
        chk("fresh_confirmed", int'(out[0]), 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NBTN; b++) begin
                if ($urandom_range(0, 15) == 0) in_r[b] = ~in_r[b];
            end
            evt_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1; cyc(2); reset = 1'b0;
            end
            cyc(1);
        end
        in_r = '0;
        evt_ready = 1'b1;
        cyc(60);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
